// File: rtl/video_pkg.sv
// Shared video types and helpers for the pattern sequencer slice.
package video_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t        RGB_BLACK       = 24'h000000;
    localparam logic [15:0] FRAME_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } seq_state_t;

    // Width of a pattern index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Frame-boundary detector: registers vsync and flags its rising edge in the
// same cycle the new level arrives.
module vsync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic vsync_i,
    output logic rise_o
);

    logic vsync_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign rise_o = vsync_i & ~vsync_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Muxes one of several RGB pattern sources onto a registered video output and
// switches sources only at frame boundaries, by request or by auto-cycling.
module pattern_sequencer
    import video_pkg::*;
#(
    parameter int NUM_PATTERNS = 4,
    parameter int AUTO_FRAMES  = 60
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  rgb_t [NUM_PATTERNS-1:0]               src_data,
    input  logic                                  in_de,
    input  logic                                  in_hsync,
    input  logic                                  in_vsync,
    input  logic                                  req_valid,
    input  logic [idx_width(NUM_PATTERNS)-1:0]    req_pattern,
    output logic                                  req_ready,
    output logic                                  req_error,
    input  logic                                  auto_en,
    output rgb_t                                  video_data,
    output logic                                  video_de,
    output logic                                  video_hsync,
    output logic                                  video_vsync,
    output logic [idx_width(NUM_PATTERNS)-1:0]    active_pattern,
    output logic [15:0]                           frame_count
);

    localparam int              IDX_W     = idx_width(NUM_PATTERNS);
    localparam logic [15:0]     AUTO_LAST = 16'(AUTO_FRAMES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] active_q, active_d;
    logic [15:0]      fcount_q, fcount_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    rgb_t             vdata_q, vdata_d;
    logic             vde_q, vhs_q, vvs_q;

    logic frame_rise;
    logic handshake;
    logic req_in_range;

    vsync_edge_detect u_vsync_edge (
        .clock   (clock),
        .reset   (reset),
        .vsync_i (in_vsync),
        .rise_o  (frame_rise)
    );

    assign handshake    = req_valid & ready_q;
    assign req_in_range = {{(32-IDX_W){1'b0}}, req_pattern} < 32'(NUM_PATTERNS);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            active_q <= '0;
            fcount_q <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            vdata_q  <= RGB_BLACK;
            vde_q    <= 1'b0;
            vhs_q    <= 1'b0;
            vvs_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            fcount_q <= fcount_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            vdata_q  <= vdata_d;
            vde_q    <= in_de;
            vhs_q    <= in_hsync;
            vvs_q    <= in_vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake && req_in_range) begin
                    state_d = ST_PENDING;
                    pend_d  = req_pattern;
                end
            end
            ST_PENDING: begin
                if (frame_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending switch wins over auto-advance; a request arriving on the
    // boundary itself is only latched here and applied one frame later.
    always_comb begin
        active_d = active_q;
        fcount_d = fcount_q;
        error_d  = (state_q == ST_IDLE) && handshake && !req_in_range;
        ready_d  = (state_d == ST_IDLE);
        if (frame_rise) begin
            if (state_q == ST_PENDING) begin
                active_d = pend_q;
                fcount_d = '0;
            end else if (auto_en && (fcount_q == AUTO_LAST)) begin
                active_d = (active_q == LAST_IDX) ? '0 : active_q + IDX_W'(1);
                fcount_d = '0;
            end else if (fcount_q != FRAME_COUNT_MAX) begin
                fcount_d = fcount_q + 16'd1;
            end
        end
        vdata_d = in_de ? src_data[active_q] : RGB_BLACK;
    end

    assign req_ready      = ready_q;
    assign req_error      = error_q;
    assign active_pattern = active_q;
    assign frame_count    = fcount_q;
    assign video_data     = vdata_q;
    assign video_de       = vde_q;
    assign video_hsync    = vhs_q;
    assign video_vsync    = vvs_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: a 20x10 timing generator, a behavioural
// reference model and a scoreboard queue for the 1-cycle video pipeline.
module tb_pattern_sequencer;
    import video_pkg::*;

    localparam int NP     = 4;
    localparam int NP3    = 3;
    localparam int AF     = 3;
    localparam int HTOTAL = 20;
    localparam int VTOTAL = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    rgb_t [NP-1:0]   src;
    rgb_t [NP3-1:0]  src3;
    logic            in_de, in_hsync, in_vsync;
    logic            req_valid, auto_en;
    logic [1:0]      req_pattern;
    logic            req_ready, req_error;
    rgb_t            video_data;
    logic            video_de, video_hsync, video_vsync;
    logic [1:0]      active_pattern;
    logic [15:0]     frame_count;

    logic            req3_valid, auto3;
    logic [1:0]      req3_pattern;
    logic            req_ready3, req_error3;
    rgb_t            video_data3;
    logic            video_de3, video_hsync3, video_vsync3;
    logic [1:0]      active_pattern3;
    logic [15:0]     frame_count3;

    pattern_sequencer #(.NUM_PATTERNS(NP), .AUTO_FRAMES(AF)) u_dut (
        .clock(clock), .reset(reset), .src_data(src),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .req_valid(req_valid), .req_pattern(req_pattern),
        .req_ready(req_ready), .req_error(req_error), .auto_en(auto_en),
        .video_data(video_data), .video_de(video_de),
        .video_hsync(video_hsync), .video_vsync(video_vsync),
        .active_pattern(active_pattern), .frame_count(frame_count)
    );

    pattern_sequencer #(.NUM_PATTERNS(NP3), .AUTO_FRAMES(AF)) u_dut3 (
        .clock(clock), .reset(reset), .src_data(src3),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .req_valid(req3_valid), .req_pattern(req3_pattern),
        .req_ready(req_ready3), .req_error(req_error3), .auto_en(auto3),
        .video_data(video_data3), .video_de(video_de3),
        .video_hsync(video_hsync3), .video_vsync(video_vsync3),
        .active_pattern(active_pattern3), .frame_count(frame_count3)
    );

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        rgb_t data;
    } vexp_t;

    vexp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int h = 0;
    int v = 0;
    bit blank = 1'b0;
    bit last_rise = 1'b0;

    bit          m_vs_prev, m_pending, m_ready, m_err, m_ready3, m_err3;
    int          m_pend_idx, m_active;
    logic [15:0] m_fc, m_fc3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, then compare all outputs.
    task automatic cycle();
        vexp_t e;
        bit    rise, hs, hs3;
        in_de    = (h < 16) && (v < 8);
        in_hsync = (h >= 17) && (h < 19);
        in_vsync = (v == VTOTAL - 1);
        for (int i = 0; i < NP; i++)
            src[i] = blank ? 24'hFFFFFF : {4'(i), 4'h5, 8'(h), 8'(v)};
        for (int i = 0; i < NP3; i++)
            src3[i] = blank ? 24'hFFFFFF : {4'(i), 4'hA, 8'(h), 8'(v)};
        rise = in_vsync && !m_vs_prev;
        hs   = req_valid && m_ready;
        hs3  = req3_valid && m_ready3;
        e = '0;
        if (reset) begin
            e.de   = in_de;
            e.hs   = in_hsync;
            e.vs   = in_vsync;
            e.data = in_de ? src[m_active] : 24'h000000;
        end
        sbq.push_back(e);

        @(posedge clock);
        #1;

        if (!reset) begin
            m_vs_prev = 0; m_pending = 0; m_pend_idx = 0; m_active = 0;
            m_fc = '0; m_ready = 0; m_err = 0;
            m_fc3 = '0; m_ready3 = 0; m_err3 = 0;
        end else begin
            m_err = 0;
            m_err3 = 0;
            if (rise) begin
                if (m_pending) begin
                    m_active = m_pend_idx; m_fc = '0; m_pending = 0;
                end else if (auto_en && m_fc == 16'(AF - 1)) begin
                    m_active = (m_active + 1) % NP; m_fc = '0;
                end else if (m_fc != 16'hFFFF) begin
                    m_fc = m_fc + 16'd1;
                end
                if (m_fc3 != 16'hFFFF) m_fc3 = m_fc3 + 16'd1;
            end
            if (hs) begin
                if (int'(req_pattern) < NP) begin
                    m_pending = 1; m_pend_idx = int'(req_pattern);
                end else begin
                    m_err = 1;
                end
            end
            if (hs3 && int'(req3_pattern) >= NP3) m_err3 = 1;
            m_ready   = !m_pending;
            m_ready3  = 1;
            m_vs_prev = in_vsync;
        end

        e = sbq.pop_front();
        chk("video_de",    video_de,    e.de);
        chk("video_hsync", video_hsync, e.hs);
        chk("video_vsync", video_vsync, e.vs);
        chk("video_data",  video_data,  e.data);
        chk("active_pattern", active_pattern, m_active);
        chk("frame_count", frame_count, m_fc);
        chk("req_ready",   req_ready,   m_ready);
        chk("req_error",   req_error,   m_err);
        chk("dut3_active", active_pattern3, 0);
        chk("dut3_fc",     frame_count3, m_fc3);
        chk("dut3_ready",  req_ready3,  m_ready3);
        chk("dut3_error",  req_error3,  m_err3);

        last_rise = rise && (reset === 1'b1);
        h++;
        if (h == HTOTAL) begin
            h = 0;
            v = (v == VTOTAL - 1) ? 0 : v + 1;
        end
    endtask

    task automatic to_boundary();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_rise && n < 2 * HTOTAL * VTOTAL);
        n_checks++;
        assert (last_rise) else begin
            n_fail++;
            $error("FAIL boundary_timeout: observed none in %0d cycles, expected a boundary", n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with active inputs.
        reset = 1'b0; auto_en = 1'b1; auto3 = 1'b0; blank = 1'b1;
        req_valid = 1'b1; req_pattern = 2'd2;
        req3_valid = 1'b1; req3_pattern = 2'd3;
        repeat (3) begin
            cycle();
            chk("rst_video_data", video_data, 0);
            chk("rst_video_de", video_de, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_active", active_pattern, 0);
            chk("rst_frame_count", frame_count, 0);
        end
        reset = 1'b1; req_valid = 1'b0; req3_valid = 1'b0;
        auto_en = 1'b0; blank = 1'b0;
        cycle();
        chk("ready_after_release", req_ready, 1);
        $display("reset released: req_ready=%0b", req_ready);

        // Mid-frame request waits for the next vsync rise.
        while (v != 3) cycle();
        req_valid = 1'b1; req_pattern = 2'd2;
        cycle();
        req_valid = 1'b0;
        chk("req_ready_pending", req_ready, 0);
        chk("req_active_held", active_pattern, 0);
        to_boundary();
        chk("req_active_switched", active_pattern, 2);
        chk("req_fc_cleared", frame_count, 0);
        chk("req_ready_back", req_ready, 1);
        $display("request pattern=2: active=%0d frame_count=%0d", active_pattern, frame_count);

        // Reset while pending discards the request; auto-cycling starts here.
        while (v != 5) cycle();
        req_valid = 1'b1; req_pattern = 2'd1;
        cycle();
        req_valid = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1; auto_en = 1'b1;
        to_boundary();
        chk("discard_active", active_pattern, 0);
        chk("discard_fc", frame_count, 1);
        $display("reset during pending: active=%0d", active_pattern);
        for (int k = 2; k <= 12; k++) begin
            to_boundary();
            chk("auto_active", active_pattern, (k / 3) % NP);
            chk("auto_fc", frame_count, k % 3);
            $display("auto frame %0d: active=%0d frame_count=%0d", k, active_pattern, frame_count);
        end

        // Pending request coincides with the auto-advance boundary.
        to_boundary();
        to_boundary();
        while (v != 4) cycle();
        req_valid = 1'b1; req_pattern = 2'd3;
        cycle();
        req_valid = 1'b0;
        to_boundary();
        chk("prio_active", active_pattern, 3);
        chk("prio_fc", frame_count, 0);
        $display("priority request pattern=3: active=%0d", active_pattern);

        // Handshake on the boundary cycle itself: auto-advance still happens.
        to_boundary();
        to_boundary();
        while (!(h == 0 && v == VTOTAL - 1)) cycle();
        req_valid = 1'b1; req_pattern = 2'd1;
        cycle();
        req_valid = 1'b0;
        chk("edge_req_auto_active", active_pattern, 0);
        chk("edge_req_fc", frame_count, 0);
        chk("edge_req_ready", req_ready, 0);
        to_boundary();
        chk("edge_req_applied", active_pattern, 1);
        chk("edge_req_fc_after", frame_count, 0);
        $display("boundary request pattern=1: active=%0d", active_pattern);

        // Out-of-range index on the 3-pattern instance.
        req3_valid = 1'b1; req3_pattern = 2'd3;
        cycle();
        req3_valid = 1'b0;
        chk("inv_error_pulse", req_error3, 1);
        chk("inv_ready", req_ready3, 1);
        chk("inv_active", active_pattern3, 0);
        cycle();
        chk("inv_error_cleared", req_error3, 0);
        $display("invalid request pattern=3: req_error pulsed");

        // White sources must still blank outside active video.
        blank = 1'b1;
        for (int i = 0; i < HTOTAL * VTOTAL; i++) begin
            cycle();
            if (video_de === 1'b0) chk("blank_data", video_data, 0);
        end
        blank = 1'b0;
        $display("blanking frame done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 4: number of pattern sources muxed onto the output, range 2..16.
REQ-002 Parameter AUTO_FRAMES, default 60: frames shown per pattern in auto-cycle mode, range 1..65535.
REQ-003 The ports SHALL be:
- clock  input  1: single clock; all logic on its rising edge.
- reset  input  1: synchronous, active-low.
- src_data  input  NUM_PATTERNS x 24: RGB888 pixel of each pattern source, already time-aligned with in_*.
- in_de, in_hsync, in_vsync  input  1 each: timing from the generator; all active-high.
- req_valid  input  1: request to switch pattern.
- req_pattern  input  $clog2(NUM_PATTERNS): requested pattern index.
- req_ready  output  1: request accepted when req_valid && req_ready.
- req_error  output  1: one-cycle pulse when an accepted index is >= NUM_PATTERNS.
- auto_en  input  1: enables auto-cycling.
- video_data  output  24: selected pixel.
- video_de, video_hsync, video_vsync  output  1 each: delayed timing.
- active_pattern  output  $clog2(NUM_PATTERNS): index currently displayed.
- frame_count  output  16: frames shown since the last pattern switch.

Function
REQ-004 The block SHALL register video_de, video_hsync and video_vsync from in_* with exactly 1 cycle of latency.
REQ-005 video_data SHALL be registered src_data[active_pattern] when in_de=1, else 24'h000000, with the same 1-cycle latency.
REQ-006 A frame boundary SHALL be the in_vsync rising edge (in_vsync=1 and the previous-cycle in_vsync=0).
REQ-007 The FSM SHALL have two states:
- IDLE: req_ready=1.
- PENDING: req_ready=0, holds the latched index.
REQ-008 In IDLE, a handshake with req_pattern < NUM_PATTERNS SHALL latch the index and move to PENDING.
REQ-009 In IDLE, a handshake with req_pattern >= NUM_PATTERNS SHALL pulse req_error for 1 cycle and stay in IDLE.
REQ-010 In PENDING, at a frame boundary the latched index SHALL load active_pattern, frame_count SHALL clear to 0 and the FSM SHALL return to IDLE, all in the same cycle.
REQ-011 Pattern changes SHALL take effect only at frame boundaries, never mid-frame.
REQ-012 At each frame boundary with no switch, frame_count SHALL increment and saturate at 16'hFFFF.
REQ-013 If auto_en=1, the FSM is IDLE and frame_count = AUTO_FRAMES-1 at a frame boundary, then:
- active_pattern SHALL advance by 1, wrapping from NUM_PATTERNS-1 to 0;
- frame_count SHALL clear to 0.
REQ-014 A pending request SHALL take priority over auto-advance at the same boundary; auto-advance is then skipped.
REQ-015 A handshake in the same cycle as a frame boundary while IDLE SHALL be latched into PENDING and applied at the next boundary.
REQ-016 An auto-advance at that same boundary SHALL still occur.
REQ-017 Deasserting auto_en SHALL freeze the pattern but not frame_count.

Reset
REQ-018 With reset=0 at a clock edge, the block SHALL force:
- video_data=0, video_de=0, video_hsync=0, video_vsync=0;
- req_ready=0, req_error=0;
- active_pattern=0, frame_count=0;
- FSM=IDLE, vsync history=0.
REQ-019 req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-020 Reset during PENDING SHALL discard the latched request.

Structure
REQ-021 The rgb_t (24-bit) type and the pattern-index width helper SHALL live in shared package video_pkg.
REQ-022 Frame-boundary detection SHALL be sub-module vsync_edge_detect, which registers in_vsync and outputs a rise pulse.
REQ-023 The FSM, counters and output registers SHALL remain in pattern_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios, using small timing (HTOTAL 20, VTOTAL 10):
- Reset: hold reset=0 for 3 cycles with active inputs -> all outputs 0; req_ready=1 on the first cycle after release.
- Request: req_pattern=2 mid-frame with auto_en=0 -> active_pattern stays 0 until the next in_vsync rise, then 2; frame_count=0; req_ready is 0 in between.
- Auto-cycle: AUTO_FRAMES=3, NUM_PATTERNS=4, auto_en=1 -> active_pattern goes 0,1,2,3,0 every 3 frames.
- Priority: a pending request for 3 coincides with the auto-advance boundary -> active_pattern=3, not +1.
- Invalid index: NUM_PATTERNS=3, req_pattern=3 -> 1-cycle req_error; no state or pattern change.
- Blanking: src_data all 24'hFFFFFF -> video_data=0 wherever video_de=0; outputs lag inputs by exactly 1 cycle.
